// File: rtl/fp_addsub_pipe.sv
// Parametrised floating-point add/subtract, three pipeline stages with a
// global valid/ready stall. Subnormals are flushed to signed zero.
module fp_addsub_pipe #(
   parameter int EXP_W     = 8,
   parameter int MAN_W     = 23,
   parameter int ROUND_RNE = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     op,
   input  logic [EXP_W+MAN_W:0]     a,
   input  logic [EXP_W+MAN_W:0]     b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [EXP_W+MAN_W:0]     y,
   output logic [2:0]               flags
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int SW = MAN_W + 4;                        // {hidden, frac, G, R, S}
   localparam int XW = EXP_W + $clog2(MAN_W + 4) + 2;    // signed exponent headroom
   localparam logic [W-1:0]         QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
   localparam logic [EXP_W-1:0]     EXP_ONES = '1;
   localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);
   localparam logic signed [XW-1:0] EXP_ZERO = '0;

   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // ---------------- stage 1: unpack, classify, swap, align ----------------
   logic                   sa, sb, za, zb, ia, ib, na, nb, a_big, big_s, small_s, shift_sticky;
   logic [EXP_W-1:0]       ea, eb, big_e, small_e, diff;
   logic [MAN_W-1:0]       fa, fb;
   logic [EXP_W+MAN_W-1:0] mag_a, mag_b;
   logic [MAN_W:0]         sig_a, sig_b, big_sig, small_sig;
   logic [SW-1:0]          small_ext, shift_mask, aligned;
   logic                   spec1;
   logic [W-1:0]           spec_y1;
   logic [2:0]             spec_f1;

   // Operand decode, magnitude swap, alignment shift and special-case result
   always_comb begin
      sa = a[W-1];
      sb = b[W-1] ^ op;
      ea = a[W-2:MAN_W];
      eb = b[W-2:MAN_W];
      fa = a[MAN_W-1:0];
      fb = b[MAN_W-1:0];
      za = (ea == '0);
      zb = (eb == '0);
      ia = (ea == EXP_ONES) && (fa == '0);
      ib = (eb == EXP_ONES) && (fb == '0);
      na = (ea == EXP_ONES) && (fa != '0);
      nb = (eb == EXP_ONES) && (fb != '0);
      mag_a = za ? '0 : {ea, fa};
      mag_b = zb ? '0 : {eb, fb};
      sig_a = za ? '0 : {1'b1, fa};
      sig_b = zb ? '0 : {1'b1, fb};
      a_big = (mag_a >= mag_b);
      if (a_big) begin
         big_e = ea; big_sig = sig_a; big_s = sa;
         small_e = eb; small_sig = sig_b; small_s = sb;
      end else begin
         big_e = eb; big_sig = sig_b; big_s = sb;
         small_e = ea; small_sig = sig_a; small_s = sa;
      end
      diff       = big_e - small_e;
      small_ext  = {small_sig, 3'b000};
      shift_mask = ~({SW{1'b1}} << diff);
      if (32'(diff) >= 32'(MAN_W + 3)) begin
         aligned      = '0;
         shift_sticky = |small_sig;
      end else begin
         aligned      = small_ext >> diff;
         shift_sticky = |(small_ext & shift_mask);
      end
      aligned[0] = aligned[0] | shift_sticky;

      spec1   = na || nb || ia || ib || (za && zb);
      spec_y1 = '0;
      spec_f1 = '0;
      if (na || nb) begin
         spec_y1 = QNAN;
      end else if (ia && ib) begin
         if (sa != sb) begin
            spec_y1 = QNAN;
            spec_f1 = 3'b100;
         end else begin
            spec_y1 = {sa, EXP_ONES, {MAN_W{1'b0}}};
         end
      end else if (ia) begin
         spec_y1 = {sa, EXP_ONES, {MAN_W{1'b0}}};
      end else if (ib) begin
         spec_y1 = {sb, EXP_ONES, {MAN_W{1'b0}}};
      end else begin
         spec_y1 = {sa && sb, {(W-1){1'b0}}};
      end
   end

   logic             v1, s1_spec, s1_sign, s1_sub;
   logic [W-1:0]     s1_spec_y;
   logic [2:0]       s1_spec_f;
   logic [EXP_W-1:0] s1_exp;
   logic [SW-1:0]    s1_big, s1_small;

   // Stage 1 register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1 <= 1'b0; s1_spec <= 1'b0; s1_sign <= 1'b0; s1_sub <= 1'b0;
         s1_spec_y <= '0; s1_spec_f <= '0; s1_exp <= '0; s1_big <= '0; s1_small <= '0;
      end else if (adv) begin
         v1        <= in_valid;
         s1_spec   <= spec1;
         s1_spec_y <= spec_y1;
         s1_spec_f <= spec_f1;
         s1_sign   <= big_s;
         s1_sub    <= big_s ^ small_s;
         s1_exp    <= big_e;
         s1_big    <= {big_sig, 3'b000};
         s1_small  <= aligned;
      end
   end

   // ---------------- stage 2: significand add/subtract ----------------
   logic             v2, s2_spec, s2_sign;
   logic [W-1:0]     s2_spec_y;
   logic [2:0]       s2_spec_f;
   logic [EXP_W-1:0] s2_exp;
   logic [SW:0]      s2_sum;

   // Stage 2 register; the swap guarantees big >= small so the difference is non-negative
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2 <= 1'b0; s2_spec <= 1'b0; s2_sign <= 1'b0;
         s2_spec_y <= '0; s2_spec_f <= '0; s2_exp <= '0; s2_sum <= '0;
      end else if (adv) begin
         v2        <= v1;
         s2_spec   <= s1_spec;
         s2_spec_y <= s1_spec_y;
         s2_spec_f <= s1_spec_f;
         s2_sign   <= s1_sign;
         s2_exp    <= s1_exp;
         s2_sum    <= s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                             : ({1'b0, s1_big} + {1'b0, s1_small});
      end
   end

   // ---------------- stage 3: normalise, round, pack ----------------
   int unsigned            lz;
   logic                   carry, g, r, s, inc;
   logic [SW-1:0]          norm;
   logic [XW-1:0]          exp_base;
   logic signed [XW-1:0]   exp_n, exp_r;
   logic [MAN_W+1:0]       mant;
   logic [MAN_W-1:0]       frac;
   logic [W-1:0]           res_y;
   logic [2:0]             res_f;

   // Leading-zero normalisation, rounding and final exception selection
   always_comb begin
      lz = 0;
      for (int unsigned i = 0; i < SW; i++) begin
         if (s2_sum[i]) lz = SW - 1 - i;
      end
      carry    = s2_sum[SW];
      exp_base = XW'(s2_exp);
      if (carry) begin
         norm  = {s2_sum[SW:2], s2_sum[1] | s2_sum[0]};
         exp_n = exp_base + XW'(1);
      end else begin
         norm  = s2_sum[SW-1:0] << lz;
         exp_n = exp_base - XW'(lz);
      end
      g     = norm[2];
      r     = norm[1];
      s     = norm[0];
      inc   = (ROUND_RNE != 0) && g && (r || s || norm[3]);
      mant  = {1'b0, norm[SW-1:3]} + (MAN_W+2)'(inc);
      exp_r = mant[MAN_W+1] ? exp_n + XW'(1) : exp_n;
      frac  = mant[MAN_W+1] ? mant[MAN_W:1] : mant[MAN_W-1:0];

      res_y = {s2_sign, exp_r[EXP_W-1:0], frac};
      res_f = {2'b00, g | r | s};
      if (s2_spec) begin
         res_y = s2_spec_y;
         res_f = s2_spec_f;
      end else if (s2_sum == '0) begin
         res_y = '0;
         res_f = '0;
      end else if (exp_r >= EXP_MAX) begin
         res_y = (ROUND_RNE != 0) ? {s2_sign, EXP_ONES, {MAN_W{1'b0}}}
                                  : {s2_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
         res_f = 3'b011;
      end else if (exp_r <= EXP_ZERO) begin
         res_y = {s2_sign, {(W-1){1'b0}}};
         res_f = 3'b001;
      end
   end

   // Output register; holds while the consumer stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         y         <= '0;
         flags     <= '0;
      end else if (adv) begin
         out_valid <= v2;
         if (v2) begin
            y     <= res_y;
            flags <= res_f;
         end
      end
   end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe: FP32 round-to-nearest-even, FP32
// truncating and FP16 instances, with backpressure and reset-in-flight cases.
module tb_fp_addsub_pipe;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string       tag;
      logic [34:0] val;
   } exp_t;
   exp_t q_m[$], q_t[$], q_h[$];
   exp_t e_m, e_t, e_h;

   // FP32 RNE instance
   logic        iv_m = 0, ir_m, op_m = 0, ov_m, ordy_m = 1;
   logic [31:0] a_m = '0, b_m = '0, y_m;
   logic [2:0]  fl_m;
   // FP32 truncating instance
   logic        iv_t = 0, ir_t, op_t = 0, ov_t, ordy_t = 1;
   logic [31:0] a_t = '0, b_t = '0, y_t;
   logic [2:0]  fl_t;
   // FP16 instance
   logic        iv_h = 0, ir_h, op_h = 0, ov_h, ordy_h = 1;
   logic [15:0] a_h = '0, b_h = '0, y_h;
   logic [2:0]  fl_h;

   fp_addsub_pipe #(.EXP_W(8), .MAN_W(23), .ROUND_RNE(1)) dut (
      .clk(clk), .rst(rst), .in_valid(iv_m), .in_ready(ir_m), .op(op_m),
      .a(a_m), .b(b_m), .out_valid(ov_m), .out_ready(ordy_m), .y(y_m), .flags(fl_m));

   fp_addsub_pipe #(.EXP_W(8), .MAN_W(23), .ROUND_RNE(0)) dut_tz (
      .clk(clk), .rst(rst), .in_valid(iv_t), .in_ready(ir_t), .op(op_t),
      .a(a_t), .b(b_t), .out_valid(ov_t), .out_ready(ordy_t), .y(y_t), .flags(fl_t));

   fp_addsub_pipe #(.EXP_W(5), .MAN_W(10), .ROUND_RNE(1)) dut_h (
      .clk(clk), .rst(rst), .in_valid(iv_h), .in_ready(ir_h), .op(op_h),
      .a(a_h), .b(b_h), .out_valid(ov_h), .out_ready(ordy_h), .y(y_h), .flags(fl_h));

   task automatic check(input string tag, input logic [34:0] got, input logic [34:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   // Result monitors: compare each handed-off result against the scoreboard head
   always @(negedge clk) begin
      if (!rst && ov_m && ordy_m) begin
         if (q_m.size() == 0) check("main_unexpected_out", 35'(ov_m), 35'(0));
         else begin
            e_m = q_m.pop_front();
            check(e_m.tag, {fl_m, y_m}, e_m.val);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && ov_t && ordy_t) begin
         if (q_t.size() == 0) check("tz_unexpected_out", 35'(ov_t), 35'(0));
         else begin
            e_t = q_t.pop_front();
            check(e_t.tag, {fl_t, y_t}, e_t.val);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && ov_h && ordy_h) begin
         if (q_h.size() == 0) check("h_unexpected_out", 35'(ov_h), 35'(0));
         else begin
            e_h = q_h.pop_front();
            check(e_h.tag, {fl_h, 16'h0000, y_h}, e_h.val);
         end
      end
   end

   // Drive one beat into instance sel, push its expected result, wait for acceptance
   task automatic send(input int sel, input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic opv, input logic [31:0] ey, input logic [2:0] ef);
      exp_t e;
      logic rdy, ok;
      e.tag = tag;
      e.val = {ef, ey};
      ok = 1'b0;
      case (sel)
         0: begin a_m = av; b_m = bv; op_m = opv; iv_m = 1'b1; q_m.push_back(e); end
         1: begin a_t = av; b_t = bv; op_t = opv; iv_t = 1'b1; q_t.push_back(e); end
         default: begin a_h = av[15:0]; b_h = bv[15:0]; op_h = opv; iv_h = 1'b1; q_h.push_back(e); end
      endcase
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         rdy = (sel == 0) ? ir_m : (sel == 1) ? ir_t : ir_h;
         @(posedge clk);
         #1;
         if (rdy) begin
            ok = 1'b1;
            break;
         end
      end
      check({tag, "_accepted"}, 35'(ok), 35'(1));
      iv_m = 1'b0; iv_t = 1'b0; iv_h = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 100; k++) begin
         if (q_m.size() == 0 && q_t.size() == 0 && q_h.size() == 0) break;
         @(negedge clk);
      end
      check(tag, 35'(q_m.size() + q_t.size() + q_h.size()), 35'(0));
      @(posedge clk);
      #1;
   endtask

   logic [31:0] bp_a [6];
   logic [31:0] bp_y [6];
   logic [31:0] y_hold;
   int          lat;
   logic        seen;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bp_a[0] = 32'h3F800000; bp_y[0] = 32'h40000000;
      bp_a[1] = 32'h40000000; bp_y[1] = 32'h40400000;
      bp_a[2] = 32'h40400000; bp_y[2] = 32'h40800000;
      bp_a[3] = 32'h40800000; bp_y[3] = 32'h40A00000;
      bp_a[4] = 32'h40A00000; bp_y[4] = 32'h40C00000;
      bp_a[5] = 32'h40C00000; bp_y[5] = 32'h40E00000;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 35'(ov_m), 35'(0));
      check("rst_y", 35'(y_m), 35'(0));
      check("rst_flags", 35'(fl_m), 35'(0));
      check("rst_in_ready", 35'(ir_m), 35'(1));
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // First beat and latency
      send(0, "add_1_2", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000);
      lat = 1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (ov_m) break;
         @(posedge clk);
         lat++;
      end
      check("latency", 35'(lat), 35'(3));
      drain("drain_first");

      // Back-to-back FP32 RNE vectors
      send(0, "sub_cancel",    32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);
      send(0, "negz_negz",     32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
      send(0, "posz_negz",     32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 3'b000);
      send(0, "subnorm_flush", 32'h00000001, 32'h00000000, 1'b0, 32'h00000000, 3'b000);
      send(0, "rne_tie_even",  32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001);
      send(0, "rne_tie_odd",   32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001);
      send(0, "sub_exact",     32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 3'b000);
      send(0, "sub_round_up",  32'h3F800000, 32'h33000000, 1'b1, 32'h3F800000, 3'b001);
      send(0, "sub_swap",      32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000);
      send(0, "zero_plus_x",   32'h00000000, 32'hC0490FDB, 1'b0, 32'hC0490FDB, 3'b000);
      send(0, "overflow",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011);
      send(0, "inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100);
      send(0, "inf_sub_ninf",  32'h7F800000, 32'hFF800000, 1'b1, 32'h7F800000, 3'b000);
      send(0, "inf_plus_one",  32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000);
      send(0, "ninf_sub_one",  32'hFF800000, 32'h3F800000, 1'b1, 32'hFF800000, 3'b000);
      send(0, "nan_in",        32'h7FC12345, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000);
      send(0, "underflow",     32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b001);
      drain("drain_main");

      // Truncating FP32 and FP16 instances
      send(1, "tz_add_1_2",    32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000);
      send(1, "tz_trunc",      32'h3F800001, 32'h33800000, 1'b0, 32'h3F800001, 3'b001);
      send(1, "tz_overflow",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F7FFFFF, 3'b011);
      send(2, "h_add_1_1",     32'h00003C00, 32'h00003C00, 1'b0, 32'h00004000, 3'b000);
      send(2, "h_cancel",      32'h00003C00, 32'h00003C00, 1'b1, 32'h00000000, 3'b000);
      send(2, "h_overflow",    32'h00007BFF, 32'h00007BFF, 1'b0, 32'h00007C00, 3'b011);
      drain("drain_tz_h");

      // Backpressure: 2-cycle stall after the first result
      fork
         begin
            for (int i = 0; i < 6; i++)
               send(0, "bp_result", bp_a[i], 32'h3F800000, 1'b0, bp_y[i], 3'b000);
         end
         begin
            seen = 1'b0;
            for (int k = 0; k < 50; k++) begin
               @(negedge clk);
               if (ov_m) begin
                  seen = 1'b1;
                  break;
               end
            end
            check("bp_first_result", 35'(seen), 35'(1));
            @(posedge clk);
            #1;
            ordy_m = 1'b0;
            @(negedge clk);
            y_hold = y_m;
            check("bp_in_ready_low0", 35'(ir_m), 35'(0));
            @(posedge clk);
            #1;
            @(negedge clk);
            check("bp_y_stable", 35'(y_m), 35'(y_hold));
            check("bp_out_valid_held", 35'(ov_m), 35'(1));
            check("bp_in_ready_low1", 35'(ir_m), 35'(0));
            @(posedge clk);
            #1;
            ordy_m = 1'b1;
         end
      join
      drain("drain_bp");

      // Reset with beats in flight
      for (int i = 0; i < 3; i++)
         send(0, "rst_beat", bp_a[i], 32'h3F800000, 1'b0, bp_y[i], 3'b000);
      rst = 1'b1;
      #1;
      check("rst_mid_out_valid", 35'(ov_m), 35'(0));
      check("rst_mid_y", 35'(y_m), 35'(0));
      q_m.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("no_stale_result", 35'(ov_m), 35'(0));
      end
      @(posedge clk);
      #1;
      send(0, "post_rst_add", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000);
      drain("drain_post_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
